// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and helpers for the multi-channel encoder counter
package enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_Z = 2'd1,
        ST_ACTIVE = 2'd2
    } chan_state_t;

    localparam int C_SYNC_STAGES = 2;

    // Select width never collapses to zero, so a single-channel build still has a 1-bit I_SEL.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_cnt_chan.sv
// rtl/enc_cnt_chan.sv - one encoder channel: sync, optional glitch filter (ENC_GLITCH_FILTER_EN), edge detect, period counter
module enc_cnt_chan
    import enc_pkg::*;
#(
    parameter int P_W    = 64,
    parameter int P_FILT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           arm,
    input  logic           a_raw,
    input  logic           z_raw,
    output logic           a_mon,
    output logic           z_mon,
    output logic [P_W-1:0] cnt_latched,
    output logic           ready,
    output logic           overflow
);

    logic [C_SYNC_STAGES-1:0] a_sync;
    logic [C_SYNC_STAGES-1:0] z_sync;
    logic                     a_lvl;
    logic                     z_lvl;
    logic                     a_dly;
    logic                     z_dly;
    logic                     a_rise;
    logic                     z_rise;
    logic [P_W-1:0]           cnt;
    logic [P_W-1:0]           cnt_next;
    chan_state_t              state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync <= '0;
            z_sync <= '0;
        end else begin
            a_sync <= {a_sync[C_SYNC_STAGES-2:0], a_raw};
            z_sync <= {z_sync[C_SYNC_STAGES-2:0], z_raw};
        end
    end

`ifdef ENC_GLITCH_FILTER_EN
    localparam int FW = $clog2(P_FILT + 1);

    logic [FW-1:0] a_fcnt;
    logic [FW-1:0] z_fcnt;

    // Level follows the synced input only once it has disagreed for P_FILT+1 samples,
    // which puts the filtered level exactly P_FILT cycles behind the unfiltered path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lvl  <= 1'b0;
            z_lvl  <= 1'b0;
            a_fcnt <= '0;
            z_fcnt <= '0;
        end else begin
            if (a_sync[C_SYNC_STAGES-1] == a_lvl) begin
                a_fcnt <= '0;
            end else if (a_fcnt == FW'(P_FILT)) begin
                a_lvl  <= a_sync[C_SYNC_STAGES-1];
                a_fcnt <= '0;
            end else begin
                a_fcnt <= a_fcnt + 1'b1;
            end
            if (z_sync[C_SYNC_STAGES-1] == z_lvl) begin
                z_fcnt <= '0;
            end else if (z_fcnt == FW'(P_FILT)) begin
                z_lvl  <= z_sync[C_SYNC_STAGES-1];
                z_fcnt <= '0;
            end else begin
                z_fcnt <= z_fcnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lvl <= 1'b0;
            z_lvl <= 1'b0;
        end else begin
            a_lvl <= a_sync[C_SYNC_STAGES-1];
            z_lvl <= z_sync[C_SYNC_STAGES-1];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dly <= 1'b0;
            z_dly <= 1'b0;
        end else begin
            a_dly <= a_lvl;
            z_dly <= z_lvl;
        end
    end

    assign a_rise   = a_lvl & ~a_dly;
    assign z_rise   = z_lvl & ~z_dly;
    assign a_mon    = a_lvl;
    assign z_mon    = z_lvl;
    assign cnt_next = a_rise ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cnt_latched <= '0;
            ready       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (!arm) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_WAIT_Z;
                        cnt      <= '0;
                        overflow <= 1'b0;
                    end
                    ST_WAIT_Z: begin
                        cnt <= '0;
                        if (z_rise) begin
                            state <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (a_rise && (&cnt)) begin
                            overflow <= 1'b1;
                        end
                        // A coincident A edge belongs to the period being closed.
                        if (z_rise) begin
                            cnt_latched <= cnt_next;
                            ready       <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/enc_cnt_multi.sv
// rtl/enc_cnt_multi.sv - N-channel encoder period counter with registered readout mux; filter via ENC_GLITCH_FILTER_EN
module enc_cnt_multi
    import enc_pkg::*;
#(
    parameter int  P_CH   = 2,
    parameter int  P_W    = 64,
    parameter int  P_FILT = 4,
    localparam int SW     = sel_width(P_CH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                I_ARM,
    input  logic [P_CH-1:0]     I_A,
    input  logic [P_CH-1:0]     I_Z,
    input  logic [SW-1:0]       I_SEL,
    output logic [P_CH-1:0]     O_A,
    output logic [P_CH-1:0]     O_Z,
    output logic [P_CH*P_W-1:0] O_CNT,
    output logic [P_W-1:0]      O_CNT_SEL,
    output logic [P_CH-1:0]     O_READY,
    output logic [P_CH-1:0]     O_OVERFLOW
);

    for (genvar g = 0; g < P_CH; g++) begin : g_chan
        enc_cnt_chan #(
            .P_W    (P_W),
            .P_FILT (P_FILT)
        ) u_chan (
            .clk         (CLK),
            .rst         (RST),
            .arm         (I_ARM),
            .a_raw       (I_A[g]),
            .z_raw       (I_Z[g]),
            .a_mon       (O_A[g]),
            .z_mon       (O_Z[g]),
            .cnt_latched (O_CNT[g*P_W +: P_W]),
            .ready       (O_READY[g]),
            .overflow    (O_OVERFLOW[g])
        );
    end

    // Out-of-range selects fall through to zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            O_CNT_SEL <= '0;
        end else begin
            O_CNT_SEL <= '0;
            for (int i = 0; i < P_CH; i++) begin
                if (I_SEL == SW'(i)) begin
                    O_CNT_SEL <= O_CNT[i*P_W +: P_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_enc_cnt_multi.sv
// tb/tb_enc_cnt_multi.sv - self-checking bench for enc_cnt_multi (P_CH=2, P_W=8; honours ENC_GLITCH_FILTER_EN)
module tb_enc_cnt_multi;

    localparam int P_CH   = 2;
    localparam int P_W    = 8;
    localparam int P_FILT = 4;
`ifdef ENC_GLITCH_FILTER_EN
    localparam int HOLD = 8;
    localparam int LAT  = 4 + P_FILT;
`else
    localparam int HOLD = 2;
    localparam int LAT  = 4;
`endif

    logic                CLK = 1'b0;
    logic                RST;
    logic                I_ARM;
    logic [P_CH-1:0]     I_A;
    logic [P_CH-1:0]     I_Z;
    logic [0:0]          I_SEL;
    logic [P_CH-1:0]     O_A;
    logic [P_CH-1:0]     O_Z;
    logic [P_CH*P_W-1:0] O_CNT;
    logic [P_W-1:0]      O_CNT_SEL;
    logic [P_CH-1:0]     O_READY;
    logic [P_CH-1:0]     O_OVERFLOW;

    enc_cnt_multi #(
        .P_CH   (P_CH),
        .P_W    (P_W),
        .P_FILT (P_FILT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .I_ARM      (I_ARM),
        .I_A        (I_A),
        .I_Z        (I_Z),
        .I_SEL      (I_SEL),
        .O_A        (O_A),
        .O_Z        (O_Z),
        .O_CNT      (O_CNT),
        .O_CNT_SEL  (O_CNT_SEL),
        .O_READY    (O_READY),
        .O_OVERFLOW (O_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ch;
        int cnt;
        bit ovf;
        int t;
    } exp_t;

    typedef struct {
        int ch;
        int n_a;
        bit simul;
        int cnt;
        bit ovf;
    } vec_t;

    exp_t           sbq[$];
    int             errors  = 0;
    int             checks  = 0;
    int             cyc     = 0;
    int             n_ready = 0;
    logic [P_W-1:0] last_cnt [P_CH];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        if (RST === 1'b0) begin
            for (int c = 0; c < P_CH; c++) begin
                if (O_READY[c]) begin
                    n_ready++;
                    if (sbq.size() == 0) begin
                        check("spurious_ready", 64'(c + 1), 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("ready_ch", 64'(c), 64'(e.ch));
                        check("ready_cnt", 64'(O_CNT[c*P_W +: P_W]), 64'(e.cnt));
                        check("ready_ovf", 64'(O_OVERFLOW[c]), 64'(e.ovf));
                        check("ready_latency", 64'(cyc - e.t), 64'(LAT));
                        last_cnt[c] = e.cnt[P_W-1:0];
                    end
                end
            end
        end
    end

    task automatic pulse(input int ch, input bit a, input bit z, input bit push, input int cnt, input bit ovf);
        exp_t e;
        @(posedge CLK);
        #2;
        I_A[ch] = a;
        I_Z[ch] = z;
        if (push) begin
            e.ch  = ch;
            e.cnt = cnt;
            e.ovf = ovf;
            e.t   = cyc;
            sbq.push_back(e);
        end
        repeat (HOLD) @(posedge CLK);
        #2;
        I_A[ch] = 1'b0;
        I_Z[ch] = 1'b0;
        repeat (HOLD) @(posedge CLK);
    endtask

    task automatic a_pulses(input int ch, input int n);
        for (int i = 0; i < n; i++) pulse(ch, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() > 0 && k < 60) begin
            @(negedge CLK);
            k++;
        end
        check("drain", 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    task automatic run_vec(input vec_t v);
        a_pulses(v.ch, v.n_a);
        pulse(v.ch, v.simul, 1'b1, 1'b1, v.cnt, v.ovf);
        drain();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t vecs[8];
        int   n0;
        bit   sel_prev;

        vecs[0] = '{0, 3, 1'b0, 3, 1'b0};
        vecs[1] = '{0, 5, 1'b0, 5, 1'b0};
        vecs[2] = '{1, 4, 1'b0, 4, 1'b0};
        vecs[3] = '{0, 6, 1'b1, 7, 1'b0};
        vecs[4] = '{0, 0, 1'b0, 0, 1'b0};
        vecs[5] = '{0, 2, 1'b0, 2, 1'b0};
        vecs[6] = '{1, 0, 1'b1, 1, 1'b0};
        vecs[7] = '{1, 9, 1'b0, 9, 1'b0};

        RST   = 1'b1;
        I_ARM = 1'b0;
        I_A   = '0;
        I_Z   = '0;
        I_SEL = 1'b0;
        for (int c = 0; c < P_CH; c++) last_cnt[c] = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cnt", 64'(O_CNT), 64'd0);
        check("rst_ready", 64'(O_READY), 64'd0);
        check("rst_ovf", 64'(O_OVERFLOW), 64'd0);
        check("rst_cnt_sel", 64'(O_CNT_SEL), 64'd0);
        check("rst_ab", 64'({O_A, O_Z}), 64'd0);
        #1;
        RST   = 1'b0;
        @(posedge CLK);
        #2;
        I_ARM = 1'b1;

        // A edges before the first index are ignored; the opening index emits nothing.
        n0 = n_ready;
        a_pulses(0, 2);
        pulse(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        pulse(1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        repeat (6) @(posedge CLK);
        check("no_ready_open", 64'(n_ready - n0), 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        check("cnt_bus", 64'(O_CNT), 64'({last_cnt[1], last_cnt[0]}));
        check("cnt_bus_model", 64'({last_cnt[1], last_cnt[0]}), 64'({8'd9, 8'd2}));

        // Readout mux: one-cycle lag while the select toggles every cycle.
        @(posedge CLK);
        #2;
        I_SEL    = 1'b1;
        sel_prev = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            check("cnt_sel", 64'(O_CNT_SEL), 64'(last_cnt[sel_prev]));
            #1;
            I_SEL    = ~I_SEL;
            sel_prev = I_SEL[0];
        end

        // Wrap: 257 edges in one period latch 1 with the sticky overflow flag.
        a_pulses(0, 257);
        pulse(0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        drain();
        check("ovf_other_ch", 64'(O_OVERFLOW[1]), 64'd0);
        run_vec('{0, 3, 1'b0, 3, 1'b1});

        // Disarm mid-period: count discarded, latch and sticky flag kept.
        a_pulses(0, 4);
        n0 = n_ready;
        @(posedge CLK);
        #2;
        I_ARM = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("disarm_no_ready", 64'(n_ready - n0), 64'd0);
        check("disarm_cnt_kept", 64'(O_CNT[P_W-1:0]), 64'(last_cnt[0]));
        check("disarm_ovf_kept", 64'(O_OVERFLOW[0]), 64'd1);
        #1;
        I_ARM = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rearm_ovf_clear", 64'(O_OVERFLOW[0]), 64'd0);
        a_pulses(0, 3);
        pulse(0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        repeat (6) @(posedge CLK);
        check("rearm_no_ready", 64'(n_ready - n0), 64'd0);
        run_vec('{0, 2, 1'b0, 2, 1'b0});

`ifdef ENC_GLITCH_FILTER_EN
        // A 2-cycle glitch never reaches the counter.
        @(posedge CLK);
        #2;
        I_A[0] = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        I_A[0] = 1'b0;
        repeat (HOLD) @(posedge CLK);
        run_vec('{0, 1, 1'b0, 1, 1'b0});
`endif

        // Reset in the middle of a period clears at once and emits nothing.
        a_pulses(0, 2);
        n0 = n_ready;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("rst_mid_cnt", 64'(O_CNT), 64'd0);
        check("rst_mid_ovf", 64'(O_OVERFLOW), 64'd0);
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        repeat (10) @(posedge CLK);
        check("rst_mid_no_ready", 64'(n_ready - n0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
